regfile_param: RTL

- Parametrised next-generation architectural register file for the Y86-64 pipeline. It serves the Decode stage (read ports) and the Write-back stage (write ports).
- Generalises the fixed 15x64 file:
  - configurable width, depth and stack-pointer reset value
  - optional write-to-read bypass
  - synchronous reset
  - sequential clear engine with request/busy/done handshake
  - defined dual-write conflict priority

---
 rtl/regfile_param.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised Y86-64 register file with two combinational
// read ports, two write ports (M wins on conflict), optional write-to-read
// bypass and a sequential clear engine with a busy/done handshake.
module regfile_param #(
  parameter int              WIDTH    = 64,
  parameter int              NREGS    = 15,
  parameter int              AW       = 4,
  parameter int              RSP_IDX  = 4,
  parameter logic [WIDTH-1:0] RSP_INIT = '0,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    srcA,
  input  logic [AW-1:0]    srcB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  input  logic [AW-1:0]    dstE,
  input  logic [WIDTH-1:0] valE,
  input  logic [AW-1:0]    dstM,
  input  logic [WIDTH-1:0] valM,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] regs [NREGS];

  // Write ports only take effect in IDLE and not in the cycle a clear is accepted.
  logic write_ok;
  assign write_ok = (state_reg == IDLE) && !clr_req;

  logic [NREGS-1:0]            wr_en;
  logic [NREGS-1:0][WIDTH-1:0] wr_data;

  // Per-register write decode: clear engine, then M port, then E port.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wdec
      localparam logic [AW-1:0]    IDX     = AW'(gi);
      localparam logic [WIDTH-1:0] CLR_VAL = (gi == RSP_IDX) ? RSP_INIT : '0;
      logic hit_e, hit_m, hit_clr;
      assign hit_e   = write_ok && (dstE == IDX);
      assign hit_m   = write_ok && (dstM == IDX);
      assign hit_clr = (state_reg == CLEAR) && (idx_reg == IDX);
      assign wr_en[gi]   = hit_e || hit_m || hit_clr;
      assign wr_data[gi] = hit_clr ? CLR_VAL : (hit_m ? valM : valE);
    end
  endgenerate

  // Register array update: reset values, else the decoded per-register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wr_en[i]) regs[i] <= wr_data[i];
    end
  end

  // Read port: zero while clearing or for the "none" index, M bypass over E.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] src);
    logic [WIDTH-1:0] r;
    r = '0;
    if (state_reg == IDLE && {1'b0, src} < NREGS_W) begin
      if (BYPASS && write_ok && dstM == src)      r = valM;
      else if (BYPASS && write_ok && dstE == src) r = valE;
      else                                        r = regs[src];
    end
    return r;
  endfunction

  // Combinational read ports.
  always_comb begin
    valA = read_port(srcA);
    valB = read_port(srcB);
  end

  // Clear engine state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  // Clear engine next-state: walk every index once, pulse done on the last.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        if (idx_reg == LAST) begin
          state_next = IDLE;
          idx_next   = '0;
          done_next  = 1'b1;
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_busy = (state_reg == CLEAR);
  assign clr_done = done_reg;

endmodule
